ahbl_sim_splitter: RTL and testbench
====================================

Name: ahbl_sim_splitter

Overview:
- 1-to-2 AHB-Lite splitter in the simulation testbench.
- Sits directly upstream of the sim control slave (port 1) and the testbench memory (port 0). Fed by the CPU's AHB-Lite master port.
- Decodes address phases, tracks which port owns the current data phase, and muxes the response back to the master.
- Unmapped accesses get a two-cycle AHB ERROR response.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width.
- S0_BASE, 32'h0000_0000, port 0 match value.
- S0_MASK, 32'hf000_0000, port 0 match mask.
- S1_BASE, 32'h8000_0000, port 1 match value.
- S1_MASK, 32'hf000_0000, port 1 match mask.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous reset, active-low.
- ahbls_hready_resp  output  1  upstream HREADYOUT.
- ahbls_hready  input  1  global HREADY.
- ahbls_hresp  output  1  upstream HRESP.
- ahbls_haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock/hwdata  input  W_ADDR/1/2/3/3/4/1/W_DATA  upstream request.
- ahbls_hrdata  output  W_DATA  upstream read data.
- ahbm0_haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock/hwdata/hready  output  same widths as upstream (hready 1)  port 0 request.
- ahbm0_hready_resp/hresp/hrdata  input  1/1/W_DATA  port 0 response.
- ahbm1_*  same as ahbm0_*  port 1.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Decode (combinational):
  - hit0 = (haddr & S0_MASK) == S0_BASE.
  - hit1 = (haddr & S1_MASK) == S1_BASE and not hit0 (port 0 wins on overlap).
  - miss = neither.
- Request forwarding:
  - haddr, hwrite, hsize, hburst, hprot, hmastlock and hwdata are broadcast to both ports unmodified.
  - ahbmN_htrans = ahbls_htrans if hitN, else 2'b00 (IDLE).
  - ahbmN_hready = ahbls_hready, on both ports.
- Data-phase owner register dsel:
  - States: NONE, S0, S1, ERR1, ERR2. Reset value NONE.
  - Update only when ahbls_hready=1:
    - htrans[1]=1 selects S0, S1 or ERR1 according to decode.
    - htrans[1]=0 selects NONE.
  - ERR1 -> ERR2 unconditionally on the next clk; ahbls_hready is 0 in ERR1, so the rule above does not apply there.
  - ERR2 behaves like any other state: it is left on the next hready=1 edge, which allows back-to-back transfers.
- Response mux:

| dsel | hready_resp | hresp | hrdata |
|---|---|---|---|
| NONE | 1 | 0 | 0 |
| S0 / S1 | ahbmN_hready_resp | ahbmN_hresp | ahbmN_hrdata |
| ERR1 | 0 | 1 | 0 |
| ERR2 | 1 | 1 | 0 |

- Latency: zero added. Combinational request path; the response path is a mux selected by a registered state.
- Wait states and errors from a port pass through. dsel holds while that port stalls.
- A new address phase presented during a stall or ERR1 is not decoded into dsel. It is still visible (masked htrans) to the hit port, which ignores it because hready=0.
- IDLE/BUSY upstream: htrans is forwarded as-is (masked on miss), and dsel becomes NONE.
- Reset mid-transfer: dsel forced to NONE. Outputs immediately take the NONE values.

Optional Feature:
- Macro: AHBL_SIM_SPLITTER_DECODE_ERR_EN.
- Defined: behaviour as above; miss -> ERR1/ERR2.
- Undefined: miss routes to port 0, i.e. hit0 = not hit1. ERR1/ERR2 are unreachable and are removed from the state encoding.

Decomposition:
- Shared package ahbl_sim_pkg:
  - HTRANS_IDLE/BUSY/NSEQ/SEQ localparams.
  - HRESP_OKAY/ERROR localparams.
  - dsel state encoding (3-bit).
- Optional sub-module ahbl_sim_addr_decode: the combinational hit/miss logic, reused by future wider splitters.
- Response mux and FSM stay in the top module.

Test Plan:
- Write 32'h8000_0000 <= 32'h41, port 1 zero-wait:
  - ahbm1_htrans=NSEQ, ahbm0_htrans=IDLE.
  - Data phase hwdata 32'h41 visible on ahbm1.
  - ahbls_hready_resp=1, ahbls_hresp=0.
- Read 32'h0000_0100, port 0 with 2 wait states, returning 32'hdead_beef:
  - ahbls_hready_resp low for 2 cycles.
  - hrdata 32'hdead_beef in the completing cycle.
  - dsel=S0 throughout.
- Read 32'h4000_0000 with macro defined:
  - Both ports see htrans=IDLE.
  - Upstream sees hready_resp 0/1 with hresp 1/1 over 2 cycles; hrdata=0.
- Same access with macro undefined: routed to port 0 (ahbm0_htrans=NSEQ), OKAY response.
- Back-to-back NSEQ 0x8000_0008 then 0x0000_0004, port 1 zero-wait:
  - Second address phase overlaps the first data phase.
  - dsel goes S1 -> S0; correct per-phase response muxing.
- Assert rst_n low during port-0 wait state:
  - ahbls_hready_resp=1, hresp=0, hrdata=0 immediately.
  - After release, a new access to 0x8000_0018 completes normally.

Source files
------------

// File: rtl/ahbl_sim_pkg.sv
// Shared AHB-Lite constants and the data-phase owner encoding for the
// simulation splitter family.
// Optional feature macro: AHBL_SIM_SPLITTER_DECODE_ERR_EN. When it is defined,
// unmapped addresses get an ERROR response. When it is undefined, unmapped
// addresses go to port 0 and the ERR states are not part of the encoding.
package ahbl_sim_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Which downstream port (if any) owns the data phase currently on the bus.
`ifdef AHBL_SIM_SPLITTER_DECODE_ERR_EN
  typedef enum logic [2:0] {
    DSEL_NONE = 3'd0,
    DSEL_S0   = 3'd1,
    DSEL_S1   = 3'd2,
    DSEL_ERR1 = 3'd3,
    DSEL_ERR2 = 3'd4
  } dsel_t;
`else
  typedef enum logic [2:0] {
    DSEL_NONE = 3'd0,
    DSEL_S0   = 3'd1,
    DSEL_S1   = 3'd2
  } dsel_t;
`endif

endpackage

// File: rtl/ahbl_sim_addr_decode.sv
// Combinational address decoder for the AHB-Lite simulation splitter.
// Port 0 takes priority where the two regions overlap.
// Optional feature macro: AHBL_SIM_SPLITTER_DECODE_ERR_EN. When it is
// undefined, every address that does not hit port 1 goes to port 0, so no
// address is left unmapped.
module ahbl_sim_addr_decode #(
  parameter int                W_ADDR  = 32,
  parameter logic [W_ADDR-1:0] S0_BASE = 32'h0000_0000,
  parameter logic [W_ADDR-1:0] S0_MASK = 32'hf000_0000,
  parameter logic [W_ADDR-1:0] S1_BASE = 32'h8000_0000,
  parameter logic [W_ADDR-1:0] S1_MASK = 32'hf000_0000
) (
  input  logic [W_ADDR-1:0] haddr,
  output logic              hit0,
  output logic              hit1
);

  localparam logic [W_ADDR-1:0] REGION_BASE [2] = '{S0_BASE, S1_BASE};
  localparam logic [W_ADDR-1:0] REGION_MASK [2] = '{S0_MASK, S1_MASK};

  // Raw region match, before overlap priority is applied.
  logic [1:0] raw_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_region
      assign raw_hit[gi] = (haddr & REGION_MASK[gi]) == REGION_BASE[gi];
    end
  endgenerate

  // Port 1 only wins when port 0 does not claim the address.
  assign hit1 = raw_hit[1] & ~raw_hit[0];

`ifdef AHBL_SIM_SPLITTER_DECODE_ERR_EN
  assign hit0 = raw_hit[0];
`else
  // Port 0 is the default route for everything that does not hit port 1.
  assign hit0 = ~hit1;
`endif

endmodule

// File: rtl/ahbl_sim_splitter.sv
// 1-to-2 AHB-Lite splitter. Port 0 is the testbench memory and port 1 is the
// sim control slave. The request path is combinational. A registered
// data-phase owner selects which response goes back to the master.
// Optional feature macro: AHBL_SIM_SPLITTER_DECODE_ERR_EN. When it is defined,
// unmapped accesses get a two-cycle ERROR response. When it is undefined,
// unmapped accesses go to port 0.
module ahbl_sim_splitter
  import ahbl_sim_pkg::*;
#(
  parameter int                W_ADDR  = 32,
  parameter int                W_DATA  = 32,
  parameter logic [W_ADDR-1:0] S0_BASE = 32'h0000_0000,
  parameter logic [W_ADDR-1:0] S0_MASK = 32'hf000_0000,
  parameter logic [W_ADDR-1:0] S1_BASE = 32'h8000_0000,
  parameter logic [W_ADDR-1:0] S1_MASK = 32'hf000_0000
) (
  input  logic              clk,
  input  logic              rst_n,

  output logic              ahbls_hready_resp,
  input  logic              ahbls_hready,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata,

  output logic [W_ADDR-1:0] ahbm0_haddr,
  output logic              ahbm0_hwrite,
  output logic [1:0]        ahbm0_htrans,
  output logic [2:0]        ahbm0_hsize,
  output logic [2:0]        ahbm0_hburst,
  output logic [3:0]        ahbm0_hprot,
  output logic              ahbm0_hmastlock,
  output logic [W_DATA-1:0] ahbm0_hwdata,
  output logic              ahbm0_hready,
  input  logic              ahbm0_hready_resp,
  input  logic              ahbm0_hresp,
  input  logic [W_DATA-1:0] ahbm0_hrdata,

  output logic [W_ADDR-1:0] ahbm1_haddr,
  output logic              ahbm1_hwrite,
  output logic [1:0]        ahbm1_htrans,
  output logic [2:0]        ahbm1_hsize,
  output logic [2:0]        ahbm1_hburst,
  output logic [3:0]        ahbm1_hprot,
  output logic              ahbm1_hmastlock,
  output logic [W_DATA-1:0] ahbm1_hwdata,
  output logic              ahbm1_hready,
  input  logic              ahbm1_hready_resp,
  input  logic              ahbm1_hresp,
  input  logic [W_DATA-1:0] ahbm1_hrdata
);

  logic  hit0;
  logic  hit1;
  dsel_t dsel_reg;

  ahbl_sim_addr_decode #(
    .W_ADDR  (W_ADDR),
    .S0_BASE (S0_BASE),
    .S0_MASK (S0_MASK),
    .S1_BASE (S1_BASE),
    .S1_MASK (S1_MASK)
  ) u_decode (
    .haddr (ahbls_haddr),
    .hit0  (hit0),
    .hit1  (hit1)
  );

  // Address-phase fields go to both ports unchanged. Only htrans is masked,
  // so a port that is not addressed sees IDLE.
  assign ahbm0_haddr     = ahbls_haddr;
  assign ahbm0_hwrite    = ahbls_hwrite;
  assign ahbm0_hsize     = ahbls_hsize;
  assign ahbm0_hburst    = ahbls_hburst;
  assign ahbm0_hprot     = ahbls_hprot;
  assign ahbm0_hmastlock = ahbls_hmastlock;
  assign ahbm0_hwdata    = ahbls_hwdata;
  assign ahbm0_hready    = ahbls_hready;
  assign ahbm0_htrans    = hit0 ? ahbls_htrans : HTRANS_IDLE;

  assign ahbm1_haddr     = ahbls_haddr;
  assign ahbm1_hwrite    = ahbls_hwrite;
  assign ahbm1_hsize     = ahbls_hsize;
  assign ahbm1_hburst    = ahbls_hburst;
  assign ahbm1_hprot     = ahbls_hprot;
  assign ahbm1_hmastlock = ahbls_hmastlock;
  assign ahbm1_hwdata    = ahbls_hwdata;
  assign ahbm1_hready    = ahbls_hready;
  assign ahbm1_htrans    = hit1 ? ahbls_htrans : HTRANS_IDLE;

  // Data-phase owner. It advances only on hready edges, so it holds while a
  // port stalls. The first error cycle always moves on to the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsel_reg <= DSEL_NONE;
`ifdef AHBL_SIM_SPLITTER_DECODE_ERR_EN
    end else if (dsel_reg == DSEL_ERR1) begin
      dsel_reg <= DSEL_ERR2;
`endif
    end else if (ahbls_hready) begin
      if (!ahbls_htrans[1]) begin
        dsel_reg <= DSEL_NONE;
`ifdef AHBL_SIM_SPLITTER_DECODE_ERR_EN
      end else if (hit0) begin
        dsel_reg <= DSEL_S0;
      end else if (hit1) begin
        dsel_reg <= DSEL_S1;
      end else begin
        dsel_reg <= DSEL_ERR1;
      end
`else
      end else if (hit1) begin
        dsel_reg <= DSEL_S1;
      end else begin
        dsel_reg <= DSEL_S0;
      end
`endif
    end
  end

  // Response mux. With no data phase in progress the splitter answers OKAY
  // itself. Errors take two cycles: a stalled ERROR cycle, then a ready one.
  always_comb begin
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = HRESP_OKAY;
    ahbls_hrdata      = '0;
    case (dsel_reg)
      DSEL_S0: begin
        ahbls_hready_resp = ahbm0_hready_resp;
        ahbls_hresp       = ahbm0_hresp;
        ahbls_hrdata      = ahbm0_hrdata;
      end
      DSEL_S1: begin
        ahbls_hready_resp = ahbm1_hready_resp;
        ahbls_hresp       = ahbm1_hresp;
        ahbls_hrdata      = ahbm1_hrdata;
      end
`ifdef AHBL_SIM_SPLITTER_DECODE_ERR_EN
      DSEL_ERR1: begin
        ahbls_hready_resp = 1'b0;
        ahbls_hresp       = HRESP_ERROR;
      end
      DSEL_ERR2: begin
        ahbls_hresp       = HRESP_ERROR;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ahbl_sim_splitter.sv
// Scoreboard testbench for ahbl_sim_splitter. The stimulus pushes the expected
// data-phase outcome of each transfer. A negedge monitor pops and compares
// each entry when the upstream data phase completes.
// Expectations follow AHBL_SIM_SPLITTER_DECODE_ERR_EN when it is defined.
module tb_ahbl_sim_splitter;
  import ahbl_sim_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ahbls_hready_resp, ahbls_hready, ahbls_hresp;
  logic [31:0] ahbls_haddr = '0;
  logic        ahbls_hwrite = 1'b0;
  logic [1:0]  ahbls_htrans = HTRANS_IDLE;
  logic [2:0]  ahbls_hsize = 3'b010;
  logic [2:0]  ahbls_hburst = 3'b000;
  logic [3:0]  ahbls_hprot = 4'b0011;
  logic        ahbls_hmastlock = 1'b0;
  logic [31:0] ahbls_hwdata = '0;
  logic [31:0] ahbls_hrdata;

  logic [31:0] ahbm0_haddr, ahbm0_hwdata, ahbm0_hrdata;
  logic        ahbm0_hwrite, ahbm0_hmastlock, ahbm0_hready, ahbm0_hready_resp, ahbm0_hresp;
  logic [1:0]  ahbm0_htrans;
  logic [2:0]  ahbm0_hsize, ahbm0_hburst;
  logic [3:0]  ahbm0_hprot;
  logic [31:0] ahbm1_haddr, ahbm1_hwdata, ahbm1_hrdata;
  logic        ahbm1_hwrite, ahbm1_hmastlock, ahbm1_hready, ahbm1_hready_resp, ahbm1_hresp;
  logic [1:0]  ahbm1_htrans;
  logic [2:0]  ahbm1_hsize, ahbm1_hburst;
  logic [3:0]  ahbm1_hprot;

  // The splitter is the only slave on the master's bus, so global HREADY is
  // its own HREADYOUT.
  assign ahbls_hready = ahbls_hready_resp;

  ahbl_sim_splitter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ahbls_hready_resp (ahbls_hready_resp),
    .ahbls_hready      (ahbls_hready),
    .ahbls_hresp       (ahbls_hresp),
    .ahbls_haddr       (ahbls_haddr),
    .ahbls_hwrite      (ahbls_hwrite),
    .ahbls_htrans      (ahbls_htrans),
    .ahbls_hsize       (ahbls_hsize),
    .ahbls_hburst      (ahbls_hburst),
    .ahbls_hprot       (ahbls_hprot),
    .ahbls_hmastlock   (ahbls_hmastlock),
    .ahbls_hwdata      (ahbls_hwdata),
    .ahbls_hrdata      (ahbls_hrdata),
    .ahbm0_haddr       (ahbm0_haddr),
    .ahbm0_hwrite      (ahbm0_hwrite),
    .ahbm0_htrans      (ahbm0_htrans),
    .ahbm0_hsize       (ahbm0_hsize),
    .ahbm0_hburst      (ahbm0_hburst),
    .ahbm0_hprot       (ahbm0_hprot),
    .ahbm0_hmastlock   (ahbm0_hmastlock),
    .ahbm0_hwdata      (ahbm0_hwdata),
    .ahbm0_hready      (ahbm0_hready),
    .ahbm0_hready_resp (ahbm0_hready_resp),
    .ahbm0_hresp       (ahbm0_hresp),
    .ahbm0_hrdata      (ahbm0_hrdata),
    .ahbm1_haddr       (ahbm1_haddr),
    .ahbm1_hwrite      (ahbm1_hwrite),
    .ahbm1_htrans      (ahbm1_htrans),
    .ahbm1_hsize       (ahbm1_hsize),
    .ahbm1_hburst      (ahbm1_hburst),
    .ahbm1_hprot       (ahbm1_hprot),
    .ahbm1_hmastlock   (ahbm1_hmastlock),
    .ahbm1_hwdata      (ahbm1_hwdata),
    .ahbm1_hready      (ahbm1_hready),
    .ahbm1_hready_resp (ahbm1_hready_resp),
    .ahbm1_hresp       (ahbm1_hresp),
    .ahbm1_hrdata      (ahbm1_hrdata)
  );

  // Port 0 slave: memory with a programmable number of wait states.
  int          p0_waits = 0;
  logic [31:0] p0_rdata = 32'h0bad_0000;
  logic        p0_active;
  int          p0_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_active <= 1'b0;
      p0_cnt    <= 0;
    end else if (ahbm0_hready) begin
      p0_active <= ahbm0_htrans[1];
      p0_cnt    <= p0_waits;
    end else if (p0_cnt > 0) begin
      p0_cnt <= p0_cnt - 1;
    end
  end
  assign ahbm0_hready_resp = !(p0_active && p0_cnt > 0);
  assign ahbm0_hresp       = 1'b0;
  assign ahbm0_hrdata      = p0_rdata;

  // Port 1 slave: zero-wait, fixed read value.
  assign ahbm1_hready_resp = 1'b1;
  assign ahbm1_hresp       = 1'b0;
  assign ahbm1_hrdata      = 32'h1234_5678;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          port;
    logic        write;
    logic [31:0] wdata;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        resp;
    int          waits;
  } exp_t;
  exp_t sb[$];

  function automatic exp_t mk(input int port, input logic write, input logic [31:0] wdata,
                              input logic chk_rdata, input logic [31:0] rdata,
                              input logic resp, input int waits);
    exp_t e;
    e.port = port; e.write = write; e.wdata = wdata; e.chk_rdata = chk_rdata;
    e.rdata = rdata; e.resp = resp; e.waits = waits;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: tracks upstream data phases and compares each one on completion.
  logic mon_pending = 1'b0;
  int   mon_waits = 0;
  logic mon_wait_resp_bad = 1'b0;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_pending = 1'b0;
        sb.delete();
      end else begin
        if (mon_pending) begin
          if (!ahbls_hready_resp) begin
            mon_waits++;
            if (sb.size() > 0 && ahbls_hresp !== sb[0].resp) mon_wait_resp_bad = 1'b1;
          end else begin
            if (sb.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL unexpected_xfer: got a completed data phase, required none");
            end else begin
              mon_e = sb.pop_front();
              check("waits", mon_waits, mon_e.waits);
              check("hresp", {31'b0, ahbls_hresp}, {31'b0, mon_e.resp});
              check("hresp_in_wait", {31'b0, mon_wait_resp_bad}, 32'd0);
              if (mon_e.chk_rdata) check("hrdata", ahbls_hrdata, mon_e.rdata);
              if (mon_e.write)
                check("hwdata", (mon_e.port == 1) ? ahbm1_hwdata : ahbm0_hwdata, mon_e.wdata);
              $display("xfer port=%0d write=%0d waits=%0d hresp=%0d hrdata=%h",
                       mon_e.port, mon_e.write, mon_waits, ahbls_hresp, ahbls_hrdata);
            end
            mon_pending = 1'b0;
          end
        end
        if (ahbls_hready_resp && ahbls_htrans[1]) begin
          mon_pending       = 1'b1;
          mon_waits         = 0;
          mon_wait_resp_bad = 1'b0;
        end
      end
    end
  end

  // Drive one NSEQ address phase and return just after the edge that accepts
  // it. On return, hwdata is set up for the data phase and htrans is IDLE.
  // route: 0/1 = expected port, 2 = neither port.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input int route, input logic push, input exp_t e);
    logic accepted;
    logic first;
    ahbls_haddr  = a;
    ahbls_hwrite = w;
    ahbls_htrans = HTRANS_NSEQ;
    if (push) sb.push_back(e);
    accepted = 1'b0;
    first    = 1'b1;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (first) begin
        check("m0_htrans", {30'b0, ahbm0_htrans}, {30'b0, (route == 0) ? HTRANS_NSEQ : HTRANS_IDLE});
        check("m1_htrans", {30'b0, ahbm1_htrans}, {30'b0, (route == 1) ? HTRANS_NSEQ : HTRANS_IDLE});
        check("m0_addr", ahbm0_haddr, a);
        check("m1_addr", ahbm1_haddr, a);
        check("bcast", {20'b0, ahbm0_hwrite, ahbm0_hsize, ahbm0_hburst, ahbm0_hprot, ahbm0_hmastlock},
              {20'b0, w, 3'b010, 3'b000, 4'b0011, 1'b0});
        check("bcast1", {20'b0, ahbm1_hwrite, ahbm1_hsize, ahbm1_hburst, ahbm1_hprot, ahbm1_hmastlock},
              {20'b0, w, 3'b010, 3'b000, 4'b0011, 1'b0});
        first = 1'b0;
      end
      accepted = ahbls_hready_resp;
      @(posedge clk); #1;
    end
    if (!accepted) begin
      n_cmp++; n_bad++;
      $display("FAIL addr_accept_timeout: got no hready, required acceptance of %h", a);
    end
    ahbls_hwdata = wd;
    ahbls_htrans = HTRANS_IDLE;
  endtask

  // Wait until every queued transfer has been compared.
  task automatic drain();
    int c;
    c = 0;
    while ((sb.size() > 0 || mon_pending) && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (sb.size() > 0 || mon_pending) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  exp_t dummy;

  initial begin
    dummy = mk(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);

    // Reset state: the splitter answers OKAY and ready by itself.
    #12;
    check("rst_hready_resp", {31'b0, ahbls_hready_resp}, 32'd1);
    check("rst_hresp", {31'b0, ahbls_hresp}, 32'd0);
    check("rst_hrdata", ahbls_hrdata, 32'h0);
    check("rst_m_hready", {30'b0, ahbm0_hready, ahbm1_hready}, 32'd3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write 0x41 to port 1 with zero wait states.
    xfer(32'h8000_0000, 1'b1, 32'h41, 1, 1'b1, mk(1, 1'b1, 32'h41, 1'b0, 32'h0, 1'b0, 0));
    drain();

    // Read from port 0 with 2 wait states.
    p0_waits = 2;
    p0_rdata = 32'hdead_beef;
    xfer(32'h0000_0100, 1'b0, 32'h0, 0, 1'b1, mk(0, 1'b0, 32'h0, 1'b1, 32'hdead_beef, 1'b0, 2));
    drain();
    p0_waits = 0;

    // Unmapped address.
    p0_rdata = 32'h4444_0000;
`ifdef AHBL_SIM_SPLITTER_DECODE_ERR_EN
    xfer(32'h4000_0000, 1'b0, 32'h0, 2, 1'b1, mk(2, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1));
`else
    xfer(32'h4000_0000, 1'b0, 32'h0, 0, 1'b1, mk(0, 1'b0, 32'h0, 1'b1, 32'h4444_0000, 1'b0, 0));
`endif
    drain();

    // Back-to-back: the port 0 address phase overlaps the port 1 data phase.
    p0_rdata = 32'hcafe_0004;
    xfer(32'h8000_0008, 1'b0, 32'h0, 1, 1'b1, mk(1, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 0));
    xfer(32'h0000_0004, 1'b0, 32'h0, 0, 1'b1, mk(0, 1'b0, 32'h0, 1'b1, 32'hcafe_0004, 1'b0, 0));
    drain();

    // BUSY is forwarded masked and leaves no data-phase owner.
    ahbls_haddr  = 32'h8000_0000;
    ahbls_htrans = HTRANS_BUSY;
    @(negedge clk);
    check("busy_m1_htrans", {30'b0, ahbm1_htrans}, {30'b0, HTRANS_BUSY});
    check("busy_m0_htrans", {30'b0, ahbm0_htrans}, {30'b0, HTRANS_IDLE});
    @(posedge clk); #1;
    ahbls_htrans = HTRANS_IDLE;
    @(negedge clk);
    check("busy_hready_resp", {31'b0, ahbls_hready_resp}, 32'd1);
    check("busy_hrdata", ahbls_hrdata, 32'h0);
    @(posedge clk); #1;

    // Reset during a port 0 wait state.
    p0_waits = 5;
    p0_rdata = 32'h5555_aaaa;
    xfer(32'h0000_0200, 1'b0, 32'h0, 0, 1'b0, dummy);
    @(negedge clk);
    check("pre_rst_stall", {31'b0, ahbls_hready_resp}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hready_resp", {31'b0, ahbls_hready_resp}, 32'd1);
    check("midrst_hresp", {31'b0, ahbls_hresp}, 32'd0);
    check("midrst_hrdata", ahbls_hrdata, 32'h0);
    p0_waits = 0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(32'h8000_0018, 1'b1, 32'h18, 1, 1'b1, mk(1, 1'b1, 32'h18, 1'b0, 32'h0, 1'b0, 0));
    xfer(32'h8000_0018, 1'b0, 32'h0, 1, 1'b1, mk(1, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
